// File: rtl/tiger_ifetch.sv
// rtl/tiger_ifetch.sv - instruction fetch stage with Avalon-MM read master; optional TIGER_IFETCH_PREFETCH_EN sequential prefetch buffer
module tiger_ifetch #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0080_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] nextpc,
  input  logic              stall_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_read,
  input  logic              imem_waitrequest,
  input  logic [31:0]       imem_readdata,
  input  logic              imem_readdatavalid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              fetch_stall
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HAVE} state_t;

  localparam logic [ADDR_W-1:0] BOOT_ALIGNED = {BOOT_ADDR[ADDR_W-1:2], 2'b00};

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] redirect_addr;
  logic [1:0]        drop_cnt;
  logic [2:0]        cnt_sum;
  logic              accept;
  logic              own_data;
  logic              advance;
  logic              discard;
  logic              drop_rsp;

  // Fetch addresses are always word aligned; low bits of nextpc are ignored
  assign redirect_addr = {nextpc[ADDR_W-1:2], 2'b00};
  assign accept        = imem_read && !imem_waitrequest;
  // A response belongs to the current fetch only when no abandoned reads are still ahead of it
  assign own_data      = imem_readdatavalid && (drop_cnt == 2'd0);
  assign advance       = (state == S_HAVE) && !stall_in;
  assign fetch_stall   = !instr_valid;

`ifdef TIGER_IFETCH_PREFETCH_EN
  logic [ADDR_W-1:0] pf_addr;
  logic [31:0]       pf_data;
  logic              pf_valid;
  logic              pf_pend;
  logic              pf_hit;

  assign pf_hit = pf_valid && (redirect_addr == pf_addr);

  // An accepted read is abandoned by a flush, or by an advance that does not use the prefetched word
  always_comb begin
    discard = (flush && ((state == S_WAIT) || accept || pf_pend)) ||
              (advance && !pf_hit && (accept || pf_pend));
  end
`else
  // An accepted read is abandoned when a flush hits while it is in flight or being accepted
  always_comb begin
    discard = flush && ((state == S_WAIT) || accept);
  end
`endif

  // A response is thrown away if older reads are outstanding, or if its own read is abandoned this cycle
  assign drop_rsp = imem_readdatavalid && ((drop_cnt != 2'd0) || discard);
  assign cnt_sum  = {1'b0, drop_cnt} + {2'b00, discard} - {2'b00, drop_rsp};

  // Track responses still owed by the memory for abandoned reads, saturating at three
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= 2'd0;
    end else begin
      drop_cnt <= (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end
  end

  // More than three abandoned reads in flight cannot be tracked
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(discard && !drop_rsp && (drop_cnt == 2'd3)));

  // Fetch sequencer: request, wait for the response, then hold the word until the pipeline takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_REQ;
      fetch_addr   <= BOOT_ALIGNED;
      imem_address <= BOOT_ALIGNED;
      imem_read    <= 1'b1;
      instr        <= 32'd0;
      pc           <= '0;
      instr_valid  <= 1'b0;
`ifdef TIGER_IFETCH_PREFETCH_EN
      pf_addr      <= '0;
      pf_data      <= 32'd0;
      pf_valid     <= 1'b0;
      pf_pend      <= 1'b0;
`endif
    end else if (flush) begin
      state        <= S_REQ;
      fetch_addr   <= redirect_addr;
      imem_address <= redirect_addr;
      imem_read    <= 1'b1;
      instr_valid  <= 1'b0;
`ifdef TIGER_IFETCH_PREFETCH_EN
      pf_valid     <= 1'b0;
      pf_pend      <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_waitrequest) begin
            state     <= S_WAIT;
            imem_read <= 1'b0;
          end
        end
        S_WAIT: begin
          if (own_data) begin
            instr       <= imem_readdata;
            pc          <= fetch_addr;
            instr_valid <= 1'b1;
            state       <= S_HAVE;
          end
        end
        S_HAVE: begin
`ifdef TIGER_IFETCH_PREFETCH_EN
          if (advance) begin
            pf_valid <= 1'b0;
            pf_pend  <= 1'b0;
            if (pf_hit) begin
              instr      <= pf_data;
              pc         <= pf_addr;
              fetch_addr <= pf_addr;
              imem_read  <= 1'b0;
            end else begin
              fetch_addr   <= redirect_addr;
              imem_address <= redirect_addr;
              imem_read    <= 1'b1;
              instr_valid  <= 1'b0;
              state        <= S_REQ;
            end
          end else if (imem_read) begin
            if (!imem_waitrequest) begin
              imem_read <= 1'b0;
              pf_pend   <= 1'b1;
            end
          end else if (pf_pend) begin
            if (own_data) begin
              pf_data  <= imem_readdata;
              pf_valid <= 1'b1;
              pf_pend  <= 1'b0;
            end
          end else if (!pf_valid) begin
            pf_addr      <= pc + ADDR_W'(4);
            imem_address <= pc + ADDR_W'(4);
            imem_read    <= 1'b1;
          end
`else
          if (advance) begin
            fetch_addr   <= redirect_addr;
            imem_address <= redirect_addr;
            imem_read    <= 1'b1;
            instr_valid  <= 1'b0;
            state        <= S_REQ;
          end
`endif
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiger_ifetch.sv
// tb/tb_tiger_ifetch.sv - table-driven and randomized self-checking bench for tiger_ifetch
module tb_tiger_ifetch;

  localparam logic [31:0] BOOT = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] nextpc;
  logic        stall_in;
  logic        flush;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic        imem_readdatavalid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fetch_stall;

  always #5 clk = ~clk;

  tiger_ifetch dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .nextpc             (nextpc),
    .stall_in           (stall_in),
    .flush              (flush),
    .imem_address       (imem_address),
    .imem_read          (imem_read),
    .imem_waitrequest   (imem_waitrequest),
    .imem_readdata      (imem_readdata),
    .imem_readdatavalid (imem_readdatavalid),
    .instr              (instr),
    .pc                 (pc),
    .instr_valid        (instr_valid),
    .fetch_stall        (fetch_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents used by the randomized phase
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] npc;
    logic        wt;
    logic        rdv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] addr;
    logic        v;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic st, input logic fl, input logic [31:0] npc,
                              input logic wt, input logic rdv, input logic [31:0] rdata,
                              input logic rd, input logic [31:0] addr,
                              input logic v, input logic [31:0] epc, input logic [31:0] einstr);
    vec_t r;
    r.stall = st;  r.flush = fl; r.npc = npc;
    r.wt    = wt;  r.rdv   = rdv; r.rdata = rdata;
    r.rd    = rd;  r.addr  = addr;
    r.v     = v;   r.epc   = epc; r.einstr = einstr;
    vt.push_back(r);
  endfunction

  task automatic do_reset();
    reset_n            = 1'b0;
    stall_in           = 1'b0;
    flush              = 1'b0;
    nextpc             = 32'd0;
    imem_waitrequest   = 1'b0;
    imem_readdatavalid = 1'b0;
    imem_readdata      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset instr", instr, 32'd0);
    check("reset pc", pc, 32'd0);
    check("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    check("reset fetch_stall", {31'd0, fetch_stall}, 32'd1);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  initial begin
    logic [31:0] wrap_pc;
    rsp_t        pend[$];
    rsp_t        r;
    int          cyc;
    int          last_due;
    int          since_flush;
    int          delivered;
    logic [31:0] exp_addr;
    logic        prev_v;
    logic        prev_hold;
    logic [31:0] prev_addr;

    wrap_pc = 32'hFFFF_FFFC + 32'd4;

    // stall flush nextpc | wait rdv rdata | read addr | valid pc instr
    add(1, 0, 32'h0000_1000, 0, 0, 32'h0,          1, BOOT,          0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_1000, 0, 1, 32'h2408_0005,  0, 32'h0,         0, 32'h0,          32'h0);
    add(1, 0, 32'h0000_1004, 0, 0, 32'h0,          0, 32'h0,         1, BOOT,           32'h2408_0005);
    add(1, 0, 32'h0000_2000, 1, 0, 32'h0,          0, 32'h0,         1, BOOT,           32'h2408_0005);
    add(1, 0, 32'h0000_3000, 0, 0, 32'h0,          0, 32'h0,         1, BOOT,           32'h2408_0005);
    add(0, 0, 32'h0000_0104, 0, 0, 32'h0,          0, 32'h0,         1, BOOT,           32'h2408_0005);
    add(0, 0, 32'h0000_5000, 1, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          32'h0);
    add(1, 0, 32'h0000_5004, 1, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_5008, 1, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_500C, 1, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          32'h0);
    add(1, 0, 32'h0000_6000, 0, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'hAAAA_0104,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_010B, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0104,  32'hAAAA_0104);
    add(0, 0, 32'h0000_7000, 0, 0, 32'h0,          1, 32'h0000_0108, 0, 32'h0,          32'h0);
    add(0, 1, 32'h8000_0180, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'hDEAD_0108,  1, 32'h8000_0180, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'h4000_0180,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0200, 0, 0, 32'h0,          0, 32'h0,         1, 32'h8000_0180,  32'h4000_0180);
    add(0, 0, 32'h0000_0000, 0, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h0,          32'h0);
    add(0, 1, 32'h0000_0300, 0, 1, 32'hBAD0_0200,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 0, 32'h0,          1, 32'h0000_0300, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'h1111_0300,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0300,  32'h1111_0300);
    add(0, 1, 32'h0000_0400, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'hBAD0_FFFC,  1, 32'h0000_0400, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'h2222_0400,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0400,  32'h2222_0400);
    add(0, 0, 32'h0000_0000, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0000_0000, 0, 1, 32'h3333_FFFC,  0, 32'h0,         0, 32'h0,          32'h0);
    add(0, 0, wrap_pc,       0, 0, 32'h0,          0, 32'h0,         1, 32'hFFFF_FFFC,  32'h3333_FFFC);
    add(1, 0, 32'h0000_0000, 1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0);

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      check($sformatf("row%0d imem_read", i), {31'd0, imem_read}, {31'd0, vt[i].rd});
      if (vt[i].rd) check($sformatf("row%0d imem_address", i), imem_address, vt[i].addr);
      check($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].v});
      check($sformatf("row%0d fetch_stall", i), {31'd0, fetch_stall}, {31'd0, !vt[i].v});
      if (vt[i].v) begin
        check($sformatf("row%0d pc", i), pc, vt[i].epc);
        check($sformatf("row%0d instr", i), instr, vt[i].einstr);
      end
      stall_in           = vt[i].stall;
      flush              = vt[i].flush;
      nextpc             = vt[i].npc;
      imem_waitrequest   = vt[i].wt;
      imem_readdatavalid = vt[i].rdv;
      imem_readdata      = vt[i].rdata;
      @(posedge clk);
      #1;
    end

    // Randomized phase: every delivered word must be memory[last redirect address]
    do_reset();
    cyc         = 0;
    last_due    = 0;
    since_flush = 10;
    delivered   = 0;
    exp_addr    = BOOT;
    prev_v      = 1'b0;
    prev_hold   = 1'b0;
    prev_addr   = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if (fetch_stall !== !instr_valid) check("rand fetch_stall", {31'd0, fetch_stall}, {31'd0, !instr_valid});
      if (prev_hold) begin
        check("rand read held", {31'd0, imem_read}, 32'd1);
        check("rand addr stable", imem_address, prev_addr);
      end
      if (imem_read && (imem_address[1:0] != 2'b00)) check("rand addr aligned", imem_address, {imem_address[31:2], 2'b00});
      if (instr_valid && !prev_v) begin
        check("rand pc", pc, exp_addr);
        check("rand instr", instr, memf(exp_addr));
        delivered++;
      end
      prev_v = instr_valid;

      stall_in = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       nextpc = $urandom;
        1:       nextpc = pc + 32'd4 + 32'($urandom_range(0, 3));
        default: nextpc = pc + 32'd4;
      endcase
      flush = (since_flush >= 4) && ($urandom_range(0, 15) == 0);

      imem_waitrequest = ($urandom_range(0, 2) == 0);
      if ((pend.size() > 0) && (pend[0].due == cyc)) begin
        imem_readdatavalid = 1'b1;
        imem_readdata      = memf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_readdatavalid = 1'b0;
        imem_readdata      = $urandom;
      end
      if (imem_read && !imem_waitrequest) begin
        r.addr   = imem_address;
        r.due    = cyc + $urandom_range(1, 3);
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
      end

      if (flush) begin
        exp_addr    = {nextpc[31:2], 2'b00};
        since_flush = 0;
      end else begin
        since_flush++;
        if (instr_valid && !stall_in) exp_addr = {nextpc[31:2], 2'b00};
      end
      prev_hold = imem_read && imem_waitrequest && !flush;
      prev_addr = imem_address;

      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand progress", {31'd0, delivered > 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
